peripheral_bus_responder: RTL
=============================

# peripheral_bus_responder

Target-side responder for the 8-bit peripheral bus (addr/size/read/write/start/bip/wait/error). It decodes a transfer started by the bus initiator and services 1/2/4/8-byte bursts against an internal byte-wide register array. It inserts a programmable number of wait states per beat and returns error beats for out-of-window accesses. It is the DUT-side counterpart of the initiator that the peripheral UVM agent drives.

## Interface
- BASE_ADDR, 16'h0000, first byte address claimed by this responder.
- MEM_DEPTH, 256, bytes of storage; power of two, 2..65536; BASE_ADDR % MEM_DEPTH == 0.
- WAIT_CYCLES, 0, wait states inserted before every beat (0..15).

- sig_clock  in  1  single clock, rising edge.
- sig_reset  in  1  asynchronous, active-low reset.
- sig_addr  in  16  start byte address; valid with sig_start.
- sig_size  in  2  burst length: 0→1, 1→2, 2→4, 3→8 beats.
- sig_read  in  1  read transfer; valid with sig_start.
- sig_write  in  1  write transfer; valid with sig_start.
- sig_start  in  1  address-phase strobe, one cycle.
- sig_bip  in  1  burst-in-progress; initiator holds high on all beats but the last.
- sig_data_in  in  8  write data, sampled on completing write beats.
- sig_data_out  out  8  read data, valid on completing read beats, else 0.
- sig_data_oe  out  1  high on completing read beats (drives the shared data wire).
- sig_wait  out  1  stall current beat.
- sig_error  out  1  current beat completes with error.
- proto_err  out  1  sticky bip-mismatch flag.

## Operation
- States: IDLE, DATA, ERR.
- IDLE: sig_start with exactly one of read/write latches addr, size, direction, beats = 1 << size, beat index 0, wait counter = WAIT_CYCLES.
  - Range check uses 17-bit arithmetic: hit iff addr ≥ BASE_ADDR and addr + beats − 1 ≤ BASE_ADDR + MEM_DEPTH − 1. A 16-bit address overflow is a miss.
  - Hit → DATA. Miss → ERR.
  - sig_start with both or neither of read/write is a NOP: stay in IDLE.
- DATA, per beat:
  - While the wait counter is nonzero: sig_wait=1, counter decrements.
  - When the counter is zero: sig_wait=0 and the beat completes this cycle.
  - Read beat: sig_data_out = mem[offset+index], sig_data_oe=1.
  - Write beat: mem[offset+index] ← sig_data_in at the closing edge.
  - After each completed beat the index increments and the counter reloads. The last beat returns to IDLE.
- ERR: same wait/beat timing as DATA, but every completing beat drives sig_error=1. No memory access; sig_data_out=0, sig_data_oe=0. The last beat returns to IDLE.
- bip check, on every completing beat in DATA or ERR: sig_bip must equal (index != beats−1). A mismatch sets proto_err. It does not alter the transfer.
- sig_start outside IDLE is ignored.
- Reset, including mid-burst: state → IDLE, all outputs 0, proto_err cleared. Memory is not reset. Write beats completed before reset persist; later beats are not written.

## Timing
- Reset values: sig_wait=0, sig_error=0, sig_data_out=0, sig_data_oe=0, proto_err=0.
- Address phase is cycle A, with sig_start=1. The first beat cycle is A+1.
- With W = WAIT_CYCLES, beat k completes at cycle A + 1 + k·(W+1) + W.
- Transfer latency is beats·(W+1) cycles after A. IDLE is re-entered at the edge ending the last beat.
- A back-to-back sig_start in the cycle immediately after the last beat is accepted.
- All outputs are decoded from registered state (no input-to-output combinational path). The exception is sig_data_out, which is an asynchronous read of the array at the registered pointer.

## Structure
- Package peripheral_bus_pkg: state enum (IDLE/DATA/ERR), SIZE_* encodings, a beats_from_size() function, and the 4-bit wait-counter width constant.
- Sub-module peripheral_bus_mem: MEM_DEPTH×8 array, one synchronous write port, one asynchronous read port, offset width $clog2(MEM_DEPTH).
- peripheral_bus_responder holds the FSM, counters, range check and bip check.

## Test plan
- Reset: assert sig_reset=0 during random activity → all outputs 0 and state IDLE within the same cycle. Release → no spurious sig_wait or sig_error.
- W=0: write size=2 at BASE+0x10 with data A1,A2,A3,A4, then read it back → sig_wait never high; four consecutive read beats return A1..A4 with sig_data_oe=1 on each.
- W=2: single-byte read at BASE+0x05 holding 0x5C → sig_wait=1 for two cycles, then 0x5C with sig_wait=0 in the third cycle after start.
- Read size=2 at BASE+MEM_DEPTH−2 → four beats with sig_error=1 and sig_data_out=0. A following read at BASE+MEM_DEPTH−2 shows memory unchanged. Address 16'hFFFE with size=3 also errors.
- sig_start with read=write=1 → no response, stays IDLE. Size=1 write with sig_bip=0 on the first beat → proto_err=1, data is still written.
- 8-byte write of 0x10..0x17 over a region prefilled with 0xFF; reset after 3 completed beats → bytes 0..2 = 0x10..0x12, bytes 3..7 = 0xFF.

Source files
------------

// File: rtl/peripheral_bus_pkg.sv
// Shared types and constants for the 8-bit peripheral bus responder.
// Burst-size encodings, FSM states and the wait-counter width live here.
package peripheral_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR  = 2'd2
    } state_e;

    localparam logic [1:0] SIZE_1 = 2'd0;
    localparam logic [1:0] SIZE_2 = 2'd1;
    localparam logic [1:0] SIZE_4 = 2'd2;
    localparam logic [1:0] SIZE_8 = 2'd3;

    localparam int WCNT_W = 4;

    function automatic logic [3:0] beats_from_size(input logic [1:0] size);
        case (size)
            SIZE_1:  beats_from_size = 4'd1;
            SIZE_2:  beats_from_size = 4'd2;
            SIZE_4:  beats_from_size = 4'd4;
            SIZE_8:  beats_from_size = 4'd8;
            default: beats_from_size = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/peripheral_bus_mem.sv
// Byte-wide register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so completed writes survive a bus reset.
module peripheral_bus_mem #(
    parameter int MEM_DEPTH = 256,
    localparam int AW = $clog2(MEM_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/peripheral_bus_responder.sv
// Target-side responder for the 8-bit peripheral bus: decodes a transfer,
// inserts wait states per beat, and services or error-terminates the burst.
module peripheral_bus_responder
    import peripheral_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        sig_clock,
    input  logic        sig_reset,
    input  logic [15:0] sig_addr,
    input  logic [1:0]  sig_size,
    input  logic        sig_read,
    input  logic        sig_write,
    input  logic        sig_start,
    input  logic        sig_bip,
    input  logic [7:0]  sig_data_in,
    output logic [7:0]  sig_data_out,
    output logic        sig_data_oe,
    output logic        sig_wait,
    output logic        sig_error,
    output logic        proto_err
);

    localparam int                AW      = $clog2(MEM_DEPTH);
    localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT_CYCLES);
    // Last claimed byte, in 17 bits so a window ending at 16'hFFFF still fits.
    localparam logic [16:0]       LIMIT   = 17'(BASE_ADDR) + 17'(MEM_DEPTH) - 17'd1;

    state_e            state, state_nxt;
    logic              is_read;
    logic [AW-1:0]     ptr;
    logic [2:0]        idx, last_idx;
    logic [WCNT_W-1:0] wcnt;

    logic              req_ok, hit, beat_done, last_beat;
    logic [3:0]        req_beats;
    logic [16:0]       req_end;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    always_comb begin
        req_beats = beats_from_size(sig_size);
        req_end   = {1'b0, sig_addr} + 17'(req_beats) - 17'd1;
        hit       = ({1'b0, sig_addr} >= 17'(BASE_ADDR)) && (req_end <= LIMIT);
        req_ok    = sig_start && (sig_read ^ sig_write);
        beat_done = (state != IDLE) && (wcnt == '0);
        last_beat = beat_done && (idx == last_idx);
        state_nxt = state;
        case (state)
            IDLE:      if (req_ok) state_nxt = hit ? DATA : ERR;
            DATA, ERR: if (last_beat) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge sig_clock or negedge sig_reset) begin
        if (!sig_reset) begin
            is_read   <= 1'b0;
            ptr       <= '0;
            idx       <= '0;
            last_idx  <= '0;
            wcnt      <= '0;
            proto_err <= 1'b0;
        end else if (state == IDLE) begin
            if (req_ok) begin
                is_read  <= sig_read;
                ptr      <= AW'(sig_addr - BASE_ADDR);
                idx      <= '0;
                last_idx <= 3'(req_beats - 4'd1);
                wcnt     <= WAIT_LD;
            end
        end else if (wcnt != '0) begin
            wcnt <= wcnt - WCNT_W'(1);
        end else begin
            idx  <= idx + 3'd1;
            ptr  <= ptr + AW'(1);
            wcnt <= WAIT_LD;
            // Initiator must drop bip exactly on the final beat.
            if (sig_bip != (idx != last_idx)) proto_err <= 1'b1;
        end
    end

    assign sig_wait     = (state != IDLE) && (wcnt != '0);
    assign sig_error    = (state == ERR) && beat_done;
    assign sig_data_oe  = (state == DATA) && beat_done && is_read;
    assign mem_we       = (state == DATA) && beat_done && !is_read;
    assign sig_data_out = sig_data_oe ? mem_rdata : 8'h00;

    peripheral_bus_mem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
        .clk   (sig_clock),
        .we    (mem_we),
        .waddr (ptr),
        .wdata (sig_data_in),
        .raddr (ptr),
        .rdata (mem_rdata)
    );

endmodule
